instr_encoder_loader: RTL

Encoder counterpart to the main control decoder. It accepts symbolic instructions (an op class plus register, immediate and target fields) over a valid/ready handshake and packs them into 32-bit MIPS words. Each word is written sequentially into instruction memory, optionally read back and verified. It is used as the boot/program loader and as the stimulus generator for datapath benches.

---
 rtl/instr_enc_pkg.sv | 84 ++++++++
 rtl/instr_encode.sv | 53 +++++
 rtl/instr_encoder_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_enc_pkg
// Brief    : Op classes, MIPS opcode/funct constants, loader error codes and
//            word-packing helpers shared by the encoder and control decoder.
// Revision : 1.0 - initial release
// ============================================================================
package instr_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_JR,
    OP_LW,
    OP_SW,
    OP_BEQ,
    OP_BNE,
    OP_ADDI,
    OP_ANDI,
    OP_ORI,
    OP_XORI,
    OP_SLTI,
    OP_SLTIU,
    OP_LUI,
    OP_J,
    OP_JAL
  } op_class_e;

  // Primary opcodes (bits 31:26)
  localparam logic [5:0] c_OPC_RTYPE = 6'h00;
  localparam logic [5:0] c_OPC_J     = 6'h02;
  localparam logic [5:0] c_OPC_JAL   = 6'h03;
  localparam logic [5:0] c_OPC_BEQ   = 6'h04;
  localparam logic [5:0] c_OPC_BNE   = 6'h05;
  localparam logic [5:0] c_OPC_ADDI  = 6'h08;
  localparam logic [5:0] c_OPC_SLTI  = 6'h0A;
  localparam logic [5:0] c_OPC_SLTIU = 6'h0B;
  localparam logic [5:0] c_OPC_ANDI  = 6'h0C;
  localparam logic [5:0] c_OPC_ORI   = 6'h0D;
  localparam logic [5:0] c_OPC_XORI  = 6'h0E;
  localparam logic [5:0] c_OPC_LUI   = 6'h0F;
  localparam logic [5:0] c_OPC_LW    = 6'h23;
  localparam logic [5:0] c_OPC_SW    = 6'h2B;

  // R-type function codes (bits 5:0)
  localparam logic [5:0] c_FN_SLL  = 6'h00;
  localparam logic [5:0] c_FN_SRL  = 6'h02;
  localparam logic [5:0] c_FN_JR   = 6'h08;
  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_XOR  = 6'h26;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;
  localparam logic [5:0] c_FN_SLTU = 6'h2B;

  localparam logic [1:0] c_ERR_NONE    = 2'd0;
  localparam logic [1:0] c_ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] c_ERR_VERIFY  = 2'd2;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {c_OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encode.sv
`default_nettype none
// ============================================================================
// Module   : instr_encode
// Brief    : Combinational packer from op class + fields to a 32-bit MIPS word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encode (
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);
  import instr_enc_pkg::*;

  // Fields the instruction does not use are forced to zero so encodings are canonical
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_ADD:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_ADD);
      OP_SUB:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_SUB);
      OP_AND:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_AND);
      OP_OR:    o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_OR);
      OP_XOR:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_XOR);
      OP_SLT:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_SLT);
      OP_SLTU:  o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_SLTU);
      OP_SLL:   o_word = pack_r(5'd0, i_rt, i_rd, i_shamt, c_FN_SLL);
      OP_SRL:   o_word = pack_r(5'd0, i_rt, i_rd, i_shamt, c_FN_SRL);
      OP_JR:    o_word = pack_r(i_rs, 5'd0, 5'd0, 5'd0, c_FN_JR);
      OP_LW:    o_word = pack_i(c_OPC_LW, i_rs, i_rt, i_imm);
      OP_SW:    o_word = pack_i(c_OPC_SW, i_rs, i_rt, i_imm);
      OP_BEQ:   o_word = pack_i(c_OPC_BEQ, i_rs, i_rt, i_imm);
      OP_BNE:   o_word = pack_i(c_OPC_BNE, i_rs, i_rt, i_imm);
      OP_ADDI:  o_word = pack_i(c_OPC_ADDI, i_rs, i_rt, i_imm);
      OP_ANDI:  o_word = pack_i(c_OPC_ANDI, i_rs, i_rt, i_imm);
      OP_ORI:   o_word = pack_i(c_OPC_ORI, i_rs, i_rt, i_imm);
      OP_XORI:  o_word = pack_i(c_OPC_XORI, i_rs, i_rt, i_imm);
      OP_SLTI:  o_word = pack_i(c_OPC_SLTI, i_rs, i_rt, i_imm);
      OP_SLTIU: o_word = pack_i(c_OPC_SLTIU, i_rs, i_rt, i_imm);
      OP_LUI:   o_word = pack_i(c_OPC_LUI, 5'd0, i_rt, i_imm);
      OP_J:     o_word = pack_j(c_OPC_J, i_target);
      OP_JAL:   o_word = pack_j(c_OPC_JAL, i_target);
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Accepts symbolic instructions, encodes them and loads them into
//            instruction memory sequentially with optional read-back verify.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0,
  parameter int VERIFY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic              imem_re,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);
  import instr_enc_pkg::*;

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_WRITE  = 3'd1;
  localparam logic [2:0] c_S_RDWAIT = 3'd2;
  localparam logic [2:0] c_S_CHECK  = 3'd3;
  localparam logic [2:0] c_S_ERR    = 3'd4;

  localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_BASE_PTR  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_PTR_MAX   = {ADDR_W{1'b1}};
  localparam logic              c_VERIFY    = (VERIFY_EN != 0);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic [1:0]        r_err_code;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_full;
  logic              w_accept;
  logic              w_verify_ok;
  logic              w_commit;

  instr_encode u_encode (
    .i_op      (in_op),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_shamt   (in_shamt),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  if (VERIFY_EN != 0) begin : g_verify
    assign w_verify_ok = (imem_rdata == r_wdata);
  end else begin : g_no_verify
    logic w_unused_rdata;
    assign w_unused_rdata = ^imem_rdata;
    assign w_verify_ok    = 1'b1;
  end

  assign w_full   = (r_count == c_DEPTH_CNT);
  assign w_accept = in_valid & in_ready;
  // A word counts as loaded once written (no verify) or once its read-back matched
  assign w_commit = ((r_state == c_S_WRITE) & ~c_VERIFY) |
                    ((r_state == c_S_CHECK) & w_verify_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else if (clear) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_illegal ? c_S_ERR : c_S_WRITE;
        end
      end
      c_S_WRITE:  w_next_state = c_VERIFY ? c_S_RDWAIT : c_S_IDLE;
      c_S_RDWAIT: w_next_state = c_S_CHECK;
      c_S_CHECK:  w_next_state = w_verify_ok ? c_S_IDLE : c_S_ERR;
      c_S_ERR:    w_next_state = c_S_ERR;
      default:    w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    imem_we  = 1'b0;
    imem_re  = 1'b0;
    in_ready = 1'b0;
    busy     = (r_state != c_S_IDLE);
    err      = (r_state == c_S_ERR);
    case (r_state)
      c_S_IDLE:   in_ready = ~w_full;
      c_S_WRITE:  imem_we  = 1'b1;
      c_S_RDWAIT: imem_re  = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= c_BASE_PTR;
      r_count    <= '0;
      r_wdata    <= '0;
      r_err_code <= c_ERR_NONE;
    end else if (clear) begin
      r_ptr      <= c_BASE_PTR;
      r_count    <= '0;
      r_err_code <= c_ERR_NONE;
    end else begin
      if (w_accept) begin
        r_wdata <= w_word;
        if (w_illegal) begin
          r_err_code <= c_ERR_ILLEGAL;
        end
      end
      if (w_commit) begin
        r_count <= r_count + (ADDR_W+1)'(1);
        // Saturate rather than wrap; full gates further writes anyway
        if (r_ptr != c_PTR_MAX) begin
          r_ptr <= r_ptr + ADDR_W'(1);
        end
      end
      if ((r_state == c_S_CHECK) && !w_verify_ok) begin
        r_err_code <= c_ERR_VERIFY;
      end
    end
  end

  assign imem_addr  = r_ptr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign full       = w_full;
  assign err_code   = r_err_code;

endmodule
`default_nettype wire
